restador_multiciclo: RTL and testbench
======================================

# restador_multiciclo

Multi-cycle add/subtract unit for the final-project datapath. It computes `entrada1 ± entrada2` on n-bit operands using an m-bit slice adder over n/m clock cycles, with the carry chained between cycles. It produces the same four status flags as the combinational ALU path: carry, negativo, desbordamiento and cero. It trades latency for a narrow adder and sits behind the ALU's operation decoder with a start/done handshake.

## Interface
- `n`, default 32: operand and result width.
- `m`, default 8: slice width. Must divide `n`; elaboration fails with `$error` otherwise. `K = n/m` is the number of slices.

- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inicio`  in  1  start request. Sampled only in REPOSO.
- `modo`  in  1  0 = suma, 1 = resta. Sampled with `inicio`.
- `entrada1`  in  n  minuend / first addend. Sampled with `inicio`.
- `entrada2`  in  n  subtrahend / second addend. Sampled with `inicio`.
- `ocupado`  out  1  high while in CALCULO.
- `listo`  out  1  one-cycle pulse; outputs below are valid and new.
- `resultado`  out  n  registered result.
- `carry`  out  1  carry-out of bit n-1. For resta, 1 means no borrow.
- `negativo`  out  1  `resultado[n-1]`.
- `desbordamiento`  out  1  signed overflow.
- `cero`  out  1  `resultado == 0`.

## Operation
- FSM `estado_t`: REPOSO, CALCULO.
- **REPOSO and `inicio`=1:**
  - Latch `entrada1` into shift register A, `entrada2` into B, `modo` into the mode register.
  - Carry register ← `modo`, slice counter ← 0, go to CALCULO.
- **CALCULO, each cycle, for slice k:**
  - `{c, s} = A[m-1:0] + (B[m-1:0] ^ {m{modo}}) + carry`.
  - Shift A and B right by m.
  - Shift `s` into the top of working register R, so R is fully ordered after K shifts.
  - carry ← c, counter +1.
- **On the cycle processing slice K-1:**
  - Commit R (including the final `s`) to `resultado` and the final c to `carry`.
  - Compute the flags from the committed value, assert `listo`, return to REPOSO.
- **Flag rules** (a, b = latched operands, r = result):
  - suma: `desbordamiento = (a[n-1]==b[n-1]) && (r[n-1]!=a[n-1])`.
  - resta: `desbordamiento = (a[n-1]!=b[n-1]) && (r[n-1]!=a[n-1])`.
- **Output holding:** outputs change only at the commit edge; they hold the previous result while `ocupado`.
- **Boundary conditions:**
  - `inicio` while in CALCULO is ignored; the latched operands and mode are unaffected.
  - `inicio` in the same cycle `listo` is high is accepted, since the FSM is already in REPOSO.
  - Operand input changes after the sampling edge have no effect.
  - `m == n` is the single-cycle case, K = 1.
  - Reset mid-operation aborts the computation. No `listo` is produced and all outputs take their reset values.

## Timing
- **Reset values:** state REPOSO, `ocupado` 0, `listo` 0, `resultado` 0, `carry` 0, `negativo` 0, `desbordamiento` 0, `cero` 0. `cero` is 0 after reset because no valid result exists yet.
- **Latency:** `inicio` sampled at edge E0 → `ocupado` high after E0 → slices processed at E1..EK → at EK `ocupado` falls and `listo` rises for exactly one cycle.
  - `listo` is high K cycles after `inicio` was sampled.
- **Throughput:** one operation per K cycles, with back-to-back issue using the `inicio`-during-`listo` rule.
- **Counter width:** `$clog2(K)` bits, minimum 1. It never wraps past K-1.

## Structure
- Package `restador_pkg`:
  - `typedef enum logic {REPOSO, CALCULO} estado_t`.
  - Constants `MODO_SUMA = 1'b0`, `MODO_RESTA = 1'b1`.
- Sub-module `sumador_rebanada` (parameter m): combinational m-bit adder with carry-in/carry-out. Instantiated once.
- Top level holds the FSM, shift registers, counter, commit logic and flag logic.
- Expected size is about 150–250 lines.

## Test plan
All cases use n = 32, m = 8 (K = 4) unless stated otherwise.
- **resta 5 − 3:** `resultado`=2, carry=1, negativo=0, desbordamiento=0, cero=0. `listo` exactly 4 cycles after `inicio`; `ocupado` high for those 4 cycles.
- **resta 3 − 5:** `resultado`=0xFFFFFFFE, carry=0, negativo=1, desbordamiento=0.
  - resta 7 − 7: `resultado`=0, cero=1, carry=1.
- **Overflow, suma:** 0x7FFFFFFF + 1 → 0x80000000, desbordamiento=1, negativo=1, carry=0.
  - suma 0xFFFFFFFF + 1 → 0, carry=1, cero=1, desbordamiento=0.
- **Overflow, resta:** 0x80000000 − 1 → 0x7FFFFFFF, desbordamiento=1, carry=1, negativo=0.
- **Handshake:**
  - Pulse `inicio` with other operands 2 cycles into a computation → ignored; the original result is returned.
  - Assert `inicio` in the `listo` cycle → the second operation completes 4 cycles later.
  - Outputs stay stable between the two `listo` pulses.
- **Reset and single-cycle:**
  - `reset` on cycle 2 of a computation → `ocupado`=0 and all outputs 0 on the next cycle, no `listo`.
  - Instance with n=m=32: 9 − 4 → `listo` 1 cycle after `inicio`, `resultado`=5.

Source files
------------

// File: rtl/restador_pkg.sv
// restador_pkg: FSM states and mode encodings for the multi-cycle add/subtract unit.
package restador_pkg;
  typedef enum logic {REPOSO, CALCULO} estado_t;
  localparam logic MODO_SUMA  = 1'b0;
  localparam logic MODO_RESTA = 1'b1;
endpackage

// File: rtl/sumador_rebanada.sv
// sumador_rebanada: combinational m-bit slice adder with carry-in and carry-out.
module sumador_rebanada #(
  parameter int m = 8
) (
  input  logic [m-1:0] a_i,
  input  logic [m-1:0] b_i,
  input  logic         c_i,
  output logic [m-1:0] s_o,
  output logic         c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + (m+1)'(c_i);
endmodule

// File: rtl/restador_multiciclo.sv
// restador_multiciclo: n-bit add/subtract over n/m cycles with one m-bit slice adder.
module restador_multiciclo
  import restador_pkg::*;
#(
  parameter int n = 32,
  parameter int m = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic         modo,
  input  logic [n-1:0] entrada1,
  input  logic [n-1:0] entrada2,
  output logic         ocupado,
  output logic         listo,
  output logic [n-1:0] resultado,
  output logic         carry,
  output logic         negativo,
  output logic         desbordamiento,
  output logic         cero
);
  localparam int K  = n / m;
  localparam int CW = K > 1 ? $clog2(K) : 1;
  if (n % m != 0) begin : g_chk
    $error("restador_multiciclo: m must divide n");
  end
  estado_t        estado_q;
  logic [n-1:0]   a_q, b_q, r_q, r_d;
  logic [CW-1:0]  cnt_q;
  logic           modo_q, c_q, sa_q, sb_q;
  logic [m-1:0]   s;
  logic           c, ultimo;
  sumador_rebanada #(.m(m)) u_sum (
    .a_i(a_q[m-1:0]),
    .b_i(b_q[m-1:0] ^ {m{modo_q}}),
    .c_i(c_q),
    .s_o(s),
    .c_o(c)
  );
  // each new slice enters at the top so slice 0 lands in the LSBs after K shifts
  assign r_d    = (r_q >> m) | (n'(s) << (n - m));
  assign ultimo = cnt_q == CW'(K - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q       <= REPOSO;
      a_q            <= '0;
      b_q            <= '0;
      r_q            <= '0;
      cnt_q          <= '0;
      modo_q         <= MODO_SUMA;
      c_q            <= 1'b0;
      sa_q           <= 1'b0;
      sb_q           <= 1'b0;
      ocupado        <= 1'b0;
      listo          <= 1'b0;
      resultado      <= '0;
      carry          <= 1'b0;
      negativo       <= 1'b0;
      desbordamiento <= 1'b0;
      cero           <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (estado_q == REPOSO) begin
        if (inicio) begin
          a_q      <= entrada1;
          b_q      <= entrada2;
          sa_q     <= entrada1[n-1];
          sb_q     <= entrada2[n-1];
          modo_q   <= modo;
          c_q      <= modo;
          cnt_q    <= '0;
          ocupado  <= 1'b1;
          estado_q <= CALCULO;
        end
      end else begin
        a_q   <= a_q >> m;
        b_q   <= b_q >> m;
        r_q   <= r_d;
        c_q   <= c;
        cnt_q <= ultimo ? '0 : cnt_q + 1'b1;
        if (ultimo) begin
          estado_q       <= REPOSO;
          ocupado        <= 1'b0;
          listo          <= 1'b1;
          resultado      <= r_d;
          carry          <= c;
          negativo       <= r_d[n-1];
          cero           <= r_d == '0;
          desbordamiento <= (modo_q == MODO_RESTA ? sa_q != sb_q : sa_q == sb_q) && (r_d[n-1] != sa_q);
        end
      end
    end
  end
endmodule

// File: tb/tb_restador_multiciclo.sv
// tb_restador_multiciclo: directed vectors plus handshake, reset and single-cycle sequences.
module tb_restador_multiciclo;
  logic        clk = 1'b0, reset = 1'b1;
  logic        inicio = 1'b0, modo = 1'b0;
  logic [31:0] entrada1 = '0, entrada2 = '0;
  logic        ocupado, listo, carry, negativo, desbordamiento, cero;
  logic [31:0] resultado;
  logic        inicio1 = 1'b0, modo1 = 1'b0;
  logic [31:0] e1_1 = '0, e2_1 = '0;
  logic        ocupado1, listo1, carry1, negativo1, desbordamiento1, cero1;
  logic [31:0] resultado1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  restador_multiciclo #(.n(32), .m(8)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .modo(modo),
    .entrada1(entrada1), .entrada2(entrada2), .ocupado(ocupado), .listo(listo),
    .resultado(resultado), .carry(carry), .negativo(negativo),
    .desbordamiento(desbordamiento), .cero(cero)
  );

  restador_multiciclo #(.n(32), .m(32)) dut1 (
    .clk(clk), .reset(reset), .inicio(inicio1), .modo(modo1),
    .entrada1(e1_1), .entrada2(e2_1), .ocupado(ocupado1), .listo(listo1),
    .resultado(resultado1), .carry(carry1), .negativo(negativo1),
    .desbordamiento(desbordamiento1), .cero(cero1)
  );

  typedef struct {
    logic        md;
    logic [31:0] a, b, r;
    logic [3:0]  f;
  } vec_t;
  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic md, input logic [31:0] x, input logic [31:0] y);
    inicio = 1'b1; modo = md; entrada1 = x; entrada2 = y;
    @(posedge clk); #1;
    inicio = 1'b0; modo = ~md; entrada1 = $urandom; entrada2 = $urandom;
  endtask

  task automatic wait_listo(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (listo) begin
        cyc = i;
        break;
      end
    end
  endtask

  function automatic logic [3:0] flags();
    return {carry, negativo, desbordamiento, cero};
  endfunction

  initial begin
    int cyc;
    logic estable;
    tv[0] = '{1'b1, 32'd5,        32'd3,        32'd2,        4'b1000};
    tv[1] = '{1'b1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0100};
    tv[2] = '{1'b1, 32'd7,        32'd7,        32'd0,        4'b1001};
    tv[3] = '{1'b0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0110};
    tv[4] = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001};
    tv[5] = '{1'b1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b1010};
    tv[6] = '{1'b0, 32'h12345678, 32'h0FEDCBA9, 32'h22222221, 4'b0000};
    tv[7] = '{1'b0, 32'h80000000, 32'h80000000, 32'd0,        4'b1011};
    tv[8] = '{1'b1, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b0100};
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_listo", 32'(listo), 32'd0);
    chk("reset_resultado", resultado, 32'd0);
    chk("reset_flags", 32'(flags()), 32'd0);
    chk("reset1_resultado", resultado1, 32'd0);
    for (int i = 0; i < 9; i++) begin
      start(tv[i].md, tv[i].a, tv[i].b);
      chk($sformatf("v%0d_ocupado", i), 32'(ocupado), 32'd1);
      wait_listo(cyc);
      chk($sformatf("v%0d_latencia", i), cyc, 32'd4);
      chk($sformatf("v%0d_resultado", i), resultado, tv[i].r);
      chk($sformatf("v%0d_flags", i), 32'(flags()), 32'(tv[i].f));
      chk($sformatf("v%0d_ocupado_fin", i), 32'(ocupado), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_listo_pulso", i), 32'(listo), 32'd0);
    end
    // inicio with other operands mid-computation must be ignored
    start(1'b1, 32'd5, 32'd3);
    @(posedge clk); #1;
    inicio = 1'b1; modo = 1'b0; entrada1 = 32'd100; entrada2 = 32'd200;
    @(posedge clk); #1;
    inicio = 1'b0;
    wait_listo(cyc);
    chk("ignora_latencia", cyc + 2, 32'd4);
    chk("ignora_resultado", resultado, 32'd2);
    chk("ignora_flags", 32'(flags()), 32'b1000);
    // back-to-back issue in the listo cycle
    start(1'b0, 32'd10, 32'd20);
    wait_listo(cyc);
    chk("b2b_primero", resultado, 32'd30);
    start(1'b1, 32'd100, 32'd1);
    chk("b2b_ocupado", 32'(ocupado), 32'd1);
    chk("b2b_listo_bajo", 32'(listo), 32'd0);
    estable = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      if (!listo && (resultado !== 32'd30 || carry !== 1'b0)) estable = 1'b0;
      @(posedge clk); #1;
      if (listo) begin
        cyc = i;
        break;
      end
    end
    chk("b2b_estable", 32'(estable), 32'd1);
    chk("b2b_latencia", cyc, 32'd4);
    chk("b2b_segundo", resultado, 32'd99);
    // reset on the second cycle of a computation
    start(1'b0, 32'h7FFFFFFF, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_listo", 32'(listo), 32'd0);
    chk("rst_resultado", resultado, 32'd0);
    chk("rst_flags", 32'(flags()), 32'd0);
    estable = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (listo || ocupado) estable = 1'b0;
    end
    chk("rst_sin_listo", 32'(estable), 32'd1);
    // single-cycle instance, K = 1
    inicio1 = 1'b1; modo1 = 1'b1; e1_1 = 32'd9; e2_1 = 32'd4;
    @(posedge clk); #1;
    inicio1 = 1'b0; e1_1 = 32'hDEADBEEF;
    chk("k1_ocupado", 32'(ocupado1), 32'd1);
    chk("k1_listo_temprano", 32'(listo1), 32'd0);
    @(posedge clk); #1;
    chk("k1_listo", 32'(listo1), 32'd1);
    chk("k1_resultado", resultado1, 32'd5);
    chk("k1_flags", 32'({carry1, negativo1, desbordamiento1, cero1}), 32'b1000);
    chk("k1_ocupado_fin", 32'(ocupado1), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
